// File: rtl/fp_addsub_arbiter_if.sv
// Bus between fp_addsub_arbiter and its environment: two requesters, the shared
// FP add/sub datapath, per-requester responses/sticky flags and hold control.
interface fp_addsub_arbiter_if;
   logic       req0_valid, req0_ready, req0_op;
   logic [7:0] req0_a, req0_b;
   logic       req1_valid, req1_ready, req1_op;
   logic [7:0] req1_a, req1_b;
   logic       fpu_valid, fpu_op;
   logic [7:0] fpu_a, fpu_b, fpu_p;
   logic [4:0] fpu_flags;
   logic       rsp0_valid, rsp1_valid;
   logic [7:0] rsp0_p, rsp1_p;
   logic [4:0] rsp0_flags, rsp1_flags, sticky0, sticky1;
   logic       clr0, clr1, hold, idle;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  fpu_p, fpu_flags, clr0, clr1, hold,
      output req0_ready, req1_ready, fpu_valid, fpu_a, fpu_b, fpu_op,
      output rsp0_valid, rsp0_p, rsp0_flags, rsp1_valid, rsp1_p, rsp1_flags,
      output sticky0, sticky1, idle
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output fpu_p, fpu_flags, clr0, clr1, hold,
      input  req0_ready, req1_ready, fpu_valid, fpu_a, fpu_b, fpu_op,
      input  rsp0_valid, rsp0_p, rsp0_flags, rsp1_valid, rsp1_p, rsp1_flags,
      input  sticky0, sticky1, idle
   );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Two-requester front end for a shared fixed-latency 8-bit FP add/sub pipe.
// FPAS_RR_EN selects round-robin arbitration; default build is fixed priority (req0 wins).
module fp_addsub_arbiter #(
   parameter int LATENCY = 3
) (
   input logic             clk,
   input logic             rst,
   fp_addsub_arbiter_if.slave bus
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

   state_e           state, state_nx;
   logic [3:0]       inflight;
   logic [LATENCY:0] vld_pipe, id_pipe;
   logic             grant_en, pick1, gnt0, gnt1, acc, rsp_any;

   // ---------------- FSM ----------------
   always_ff @(posedge clk)
      if (rst) state <= RUN;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         RUN:     if (bus.hold) state_nx = (inflight == 4'd0) ? HALTED : DRAIN;
         DRAIN:   if (!bus.hold) state_nx = RUN;
                  else if (inflight == 4'd0) state_nx = HALTED;
         HALTED:  if (!bus.hold) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   // Releasing hold leaves DRAIN/HALTED for RUN in the same cycle, so the
   // pending request is granted without a dead cycle.
   always_comb begin
      grant_en = 1'b0;
      unique case (state)
         RUN:     grant_en = ~bus.hold;
         DRAIN,
         HALTED:  grant_en = ~bus.hold;
         default: grant_en = 1'b0;
      endcase
   end

   // ---------------- arbitration ----------------
`ifdef FPAS_RR_EN
   logic rr_ptr;  // 1: req1 has priority on a tie
   always_ff @(posedge clk)
      if (rst)       rr_ptr <= 1'b0;
      else if (gnt0) rr_ptr <= 1'b1;
      else if (gnt1) rr_ptr <= 1'b0;
   assign pick1 = bus.req1_valid & (~bus.req0_valid | rr_ptr);
`else
   assign pick1 = bus.req1_valid & ~bus.req0_valid;
`endif

   assign gnt1           = grant_en & pick1;
   assign gnt0           = grant_en & bus.req0_valid & ~pick1;
   assign acc            = gnt0 | gnt1;
   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   // ---------------- issue ----------------
   always_ff @(posedge clk)
      if (rst) begin
         bus.fpu_valid <= 1'b0;
         bus.fpu_a     <= '0;
         bus.fpu_b     <= '0;
         bus.fpu_op    <= 1'b0;
      end else begin
         bus.fpu_valid <= acc;
         if (acc) begin
            bus.fpu_a  <= gnt1 ? bus.req1_a  : bus.req0_a;
            bus.fpu_b  <= gnt1 ? bus.req1_b  : bus.req0_b;
            bus.fpu_op <= gnt1 ? bus.req1_op : bus.req0_op;
         end
      end

   // Stage k holds the op issued k cycles ago; stage LATENCY lines up with fpu_p.
   always_ff @(posedge clk)
      if (rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LATENCY-1:0], acc};
         id_pipe  <= {id_pipe[LATENCY-1:0], gnt1};
      end

   // ---------------- response routing ----------------
   always_ff @(posedge clk)
      if (rst) begin
         bus.rsp0_valid <= 1'b0;
         bus.rsp0_p     <= '0;
         bus.rsp0_flags <= '0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp1_p     <= '0;
         bus.rsp1_flags <= '0;
      end else begin
         bus.rsp0_valid <= vld_pipe[LATENCY] & ~id_pipe[LATENCY];
         bus.rsp1_valid <= vld_pipe[LATENCY] &  id_pipe[LATENCY];
         if (vld_pipe[LATENCY] & ~id_pipe[LATENCY]) begin
            bus.rsp0_p     <= bus.fpu_p;
            bus.rsp0_flags <= bus.fpu_flags;
         end
         if (vld_pipe[LATENCY] & id_pipe[LATENCY]) begin
            bus.rsp1_p     <= bus.fpu_p;
            bus.rsp1_flags <= bus.fpu_flags;
         end
      end

   // Clear wins over history but never over the flags arriving this cycle.
   always_ff @(posedge clk)
      if (rst) begin
         bus.sticky0 <= '0;
         bus.sticky1 <= '0;
      end else begin
         if (bus.rsp0_valid) bus.sticky0 <= bus.clr0 ? bus.rsp0_flags : (bus.sticky0 | bus.rsp0_flags);
         else if (bus.clr0)  bus.sticky0 <= '0;
         if (bus.rsp1_valid) bus.sticky1 <= bus.clr1 ? bus.rsp1_flags : (bus.sticky1 | bus.rsp1_flags);
         else if (bus.clr1)  bus.sticky1 <= '0;
      end

   // ---------------- in-flight accounting ----------------
   assign rsp_any = bus.rsp0_valid | bus.rsp1_valid;

   always_ff @(posedge clk)
      if (rst) inflight <= '0;
      else
         unique case ({acc, rsp_any})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   inflight <= inflight - 4'd1;
            default: inflight <= inflight;
         endcase

   assign bus.idle = (inflight == 4'd0);
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Randomized + directed bench for fp_addsub_arbiter against a cycle-indexed
// expectation schedule; includes a stand-in datapath with a fixed latency.
module tb_fp_addsub_arbiter;
  localparam int LATENCY = 3;
  localparam int NC      = 2048;

  typedef struct packed { logic v; logic id; logic [7:0] a; logic [7:0] b; logic op; } iss_t;
  typedef struct packed { logic v; logic id; logic [7:0] p; logic [4:0] f; } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_arbiter_if bus();
  fp_addsub_arbiter #(.LATENCY(LATENCY)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-in datapath (not IEEE): equal operands add -> exponent+1, else a keyed mix; flags = b[4:0].
  function automatic logic [12:0] fpm(input logic [7:0] a, input logic [7:0] b, input logic op);
    if (!op && a == b && a[6:4] != 3'd7) return {a[7], a[6:4] + 3'd1, a[3:0], 5'h00};
    return {a ^ {b[3:0], b[7:4]} ^ {7'd0, op}, b[4:0]};
  endfunction

  logic [12:0] sp [LATENCY];
  always_ff @(posedge clk) begin
    sp[0] <= fpm(bus.fpu_a, bus.fpu_b, bus.fpu_op);
    for (int k = 1; k < LATENCY; k++) sp[k] <= sp[k-1];
  end
  assign bus.fpu_p     = sp[LATENCY-1][12:5];
  assign bus.fpu_flags = sp[LATENCY-1][4:0];

  int         nvec, nerr, cyc;
  logic [7:0] a0, b0, a1, b1;
  logic       op0, op1, pri1;
  logic [4:0] st0, st1;
  int         due[$];
  iss_t       e_iss [NC];
  rsp_t       e_rsp [NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at negedge against the schedule, advance the model.
  task automatic step(input logic v0, input logic v1, input logic hd,
                      input logic c0, input logic c1, input logic r);
    logic w1, eg0, eg1;
    iss_t ei;
    rsp_t er;
    logic [12:0] m;
    if (cyc >= NC - 16) begin
      $display("FAIL cycle_budget cyc=%0d", cyc);
      $fatal(1);
    end
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    bus.hold = hd; bus.clr0 = c0; bus.clr1 = c1; rst = r;
    @(negedge clk);
    ei = e_iss[cyc];
    er = e_rsp[cyc];
    while (due.size() > 0 && due[0] < cyc) void'(due.pop_front());
`ifdef FPAS_RR_EN
    w1 = v1 & (~v0 | pri1);
`else
    w1 = v1 & ~v0;
`endif
    eg1 = ~hd & w1;
    eg0 = ~hd & v0 & ~w1;
    chk("req0_ready", bus.req0_ready, eg0);
    chk("req1_ready", bus.req1_ready, eg1);
    chk("fpu_valid", bus.fpu_valid, ei.v);
    if (ei.v) begin
      chk("fpu_a", bus.fpu_a, ei.a);
      chk("fpu_b", bus.fpu_b, ei.b);
      chk("fpu_op", bus.fpu_op, ei.op);
    end
    chk("rsp0_valid", bus.rsp0_valid, er.v & ~er.id);
    chk("rsp1_valid", bus.rsp1_valid, er.v & er.id);
    if (er.v && !er.id) begin
      chk("rsp0_p", bus.rsp0_p, er.p);
      chk("rsp0_flags", bus.rsp0_flags, er.f);
    end
    if (er.v && er.id) begin
      chk("rsp1_p", bus.rsp1_p, er.p);
      chk("rsp1_flags", bus.rsp1_flags, er.f);
    end
    chk("sticky0", bus.sticky0, st0);
    chk("sticky1", bus.sticky1, st1);
    chk("idle", bus.idle, due.size() == 0);
    if (r) begin
      for (int k = cyc + 1; k < NC; k++) begin e_iss[k] = '0; e_rsp[k] = '0; end
      st0 = '0; st1 = '0; pri1 = 1'b0;
      due.delete();
    end else begin
      if (eg0 | eg1) begin
        m = eg1 ? fpm(a1, b1, op1) : fpm(a0, b0, op0);
        e_iss[cyc+1].v  = 1'b1;
        e_iss[cyc+1].id = eg1;
        e_iss[cyc+1].a  = eg1 ? a1 : a0;
        e_iss[cyc+1].b  = eg1 ? b1 : b0;
        e_iss[cyc+1].op = eg1 ? op1 : op0;
        e_rsp[cyc+LATENCY+2].v  = 1'b1;
        e_rsp[cyc+LATENCY+2].id = eg1;
        e_rsp[cyc+LATENCY+2].p  = m[12:5];
        e_rsp[cyc+LATENCY+2].f  = m[4:0];
        due.push_back(cyc + LATENCY + 2);
        pri1 = eg0;
        if (eg0) begin a0 = 8'($urandom); b0 = 8'($urandom); op0 = 1'($urandom); end
        else     begin a1 = 8'($urandom); b1 = 8'($urandom); op1 = 1'($urandom); end
      end
      if (er.v && !er.id) st0 = c0 ? er.f : (st0 | er.f);
      else if (c0)        st0 = '0;
      if (er.v && er.id)  st1 = c1 ? er.f : (st1 | er.f);
      else if (c1)        st1 = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] pk;
    logic       c1;
    nvec = 0; nerr = 0; cyc = 0;
    st0 = '0; st1 = '0; pri1 = 1'b0;
    for (int k = 0; k < NC; k++) begin e_iss[k] = '0; e_rsp[k] = '0; end
    a0 = 8'h00; b0 = 8'h00; op0 = 1'b0; a1 = 8'h00; b1 = 8'h00; op1 = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 1'b0;
    bus.hold = 1'b0; bus.clr0 = 1'b0; bus.clr1 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_idle", bus.idle, 1);
    chk("rst_fpu_valid", bus.fpu_valid, 0);
    chk("rst_fpu_a", bus.fpu_a, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp0_p", bus.rsp0_p, 0);
    chk("rst_sticky0", bus.sticky0, 0);
    chk("rst_sticky1", bus.sticky1, 0);

    // single op: 0x30 + 0x30 -> 0x40 after LATENCY+2
    a0 = 8'h30; b0 = 8'h30; op0 = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_n(8);
    chk("single_rsp0_p", bus.rsp0_p, 8'h40);

    // both requesters valid for four cycles
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_n(8);

    // sticky accumulation and clear-with-arrival
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    a1 = 8'h11; b1 = 8'h01; op1 = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    a1 = 8'h22; b1 = 8'h10; op1 = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_n(6);
    chk("stk1_acc", bus.sticky1, 5'h11);
    chk("stk0_acc", bus.sticky0, 5'h00);
    a1 = 8'h33; b1 = 8'h04; op1 = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) begin
      c1 = e_rsp[cyc].v & e_rsp[cyc].id;
      step(1'b0, 1'b0, 1'b0, 1'b0, c1, 1'b0);
    end
    chk("stk1_clr", bus.sticky1, 5'h04);

    // random traffic with occasional hold and clears
    repeat (300)
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 1'b0);
    idle_n(8);

    // hold/drain: three in flight, hold, then release with req1 waiting
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("drain_idle", bus.idle, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_n(8);

    // reset one cycle after two issues
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_rsp0_p", bus.rsp0_p, 0);
    chk("mid_rst_idle", bus.idle, 1);
    idle_n(8);

    // saturation: ten back-to-back ops from req0
    pk = '0;
    repeat (10) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (u_dut.inflight > pk) pk = u_dut.inflight;
    end
    repeat (8) begin
      idle_n(1);
      if (u_dut.inflight > pk) pk = u_dut.inflight;
    end
    chk("infl_peak", pk, LATENCY + 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Shares one pipelined 8-bit FP add/sub datapath (fixed latency, ending in the exception stage) between two requesters.
- Arbitrates requests over valid/ready handshakes, issues operands, and tracks in-flight ops by tag.
- Routes each result plus its 5-bit exception flags back to the originating requester.
- Keeps a per-requester sticky exception status register and supports a hold/drain sequence for reconfiguration or shutdown.

Parameters:
- LATENCY, 3, cycles from fpu_valid high to fpu_p/fpu_flags valid at the datapath output; legal range 1..8.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 op accepted this cycle
- req0_a  input  8  operand A (sign, exp[6:4], mant[3:0])
- req0_b  input  8  operand B
- req0_op  input  1  0 = add, 1 = subtract
- req1_valid / req1_ready / req1_a / req1_b / req1_op: same as requester 0, for requester 1
- fpu_valid  output  1  issue strobe to datapath
- fpu_a  output  8  issued operand A
- fpu_b  output  8  issued operand B
- fpu_op  output  1  issued operation
- fpu_p  input  8  datapath result
- fpu_flags  input  5  {Overflow, Underflow, DivideByZero, Invalid, Inexact}
- rsp0_valid  output  1  result for requester 0, one-cycle pulse, no backpressure
- rsp0_p  output  8  result value
- rsp0_flags  output  5  per-op flags
- rsp1_valid / rsp1_p / rsp1_flags: same as requester 0, for requester 1
- sticky0  output  5  OR-accumulated flags for requester 0
- sticky1  output  5  OR-accumulated flags for requester 1
- clr0  input  1  clear sticky0
- clr1  input  1  clear sticky1
- hold  input  1  stop accepting new ops
- idle  output  1  no op in flight and none being issued

Behaviour:
- Reset values:
  - all outputs 0, except idle = 1;
  - FSM = RUN; round-robin pointer favours req0; tag pipe and inflight count cleared.
  - Reset mid-operation discards all in-flight ops; no rsp pulses after reset, even though the datapath still drains.
- Grant (combinational):
  - In RUN only, at most one reqN_ready per cycle, asserted when that reqN_valid is high and it wins arbitration.
  - Accept = valid & ready.
  - reqN_ready is never high when reqN_valid is low.
- Issue:
  - On accept in cycle t, fpu_valid/fpu_a/fpu_b/fpu_op are registered and valid in cycle t+1; fpu_valid is low otherwise.
  - Throughput is one op per cycle.
- Tag pipe:
  - LATENCY+1 stage shift register of {valid, requester id}, loaded at issue.
  - For an issue at t+1, fpu_p/fpu_flags are sampled at t+1+LATENCY.
  - rspN_valid/p/flags are registered at t+2+LATENCY. Total accept-to-response = LATENCY+2 cycles; ordering is strictly in order.
  - rsp outputs hold their last value while valid is low; the unselected rsp port's valid stays 0.
- Sticky:
  - On rspN_valid, stickyN <= stickyN | flags.
  - If clrN and a new response arrive in the same cycle, stickyN <= new flags (clear first, the new event is not lost).
  - clrN alone gives 0.
- Inflight counter:
  - Width 4.
  - +1 on accept, -1 on response; simultaneous +1/-1 leaves it unchanged.
  - Never exceeds LATENCY+2.
- FSM:
  - RUN -> DRAIN when hold=1 and inflight>0.
  - RUN -> HALTED when hold=1 and inflight==0.
  - DRAIN -> HALTED when inflight reaches 0.
  - DRAIN or HALTED -> RUN when hold=0. From DRAIN, in-flight ops continue to complete.
  - hold takes effect on grants in the same cycle: ready is low from the cycle hold is high.
- idle = (inflight==0) in any state. It is 1 in HALTED.

Optional Feature:
- Macro FPAS_RR_EN.
- Defined: round-robin arbitration.
  - After a grant to reqN, the other requester has priority next time.
  - With both valid continuously, grants alternate 0,1,0,1.
- Undefined: fixed priority.
  - req0 always wins; req1 is granted only when req0_valid is low.
  - The pointer register is removed.

Test Plan:
- Single op, LATENCY=3: req0 a=0x30, b=0x30, op=0 accepted at cycle 0 -> fpu_valid, fpu_a=0x30 at cycle 1. Model returns fpu_p=0x40, flags=0x00 at cycle 4 -> rsp0_valid, rsp0_p=0x40 at cycle 5; rsp1_valid stays 0; idle returns to 1.
- Both valid for 4 cycles with FPAS_RR_EN -> grant order 0,1,0,1. Responses come back in the same order with matching ids, one per cycle. Without the macro -> four req0 grants, req1 starved.
- Sticky accumulation: req1 responses with flags 0x01 then 0x10 -> sticky1=0x11, sticky0=0x00. clr1 asserted on the cycle a 0x04 flag response arrives -> sticky1=0x04.
- Hold/drain: three ops in flight, then hold=1 -> ready low immediately, FSM in DRAIN. The three responses are delivered, then HALTED with idle=1. Release hold -> the next request is granted in the same cycle.
- Reset mid-flight: rst pulsed one cycle after two issues -> no rsp pulses afterwards; sticky=0, idle=1, FSM RUN.
- Back-to-back saturation: req0 valid for 10 cycles -> inflight peaks at 5 with LATENCY=3 and 10 responses arrive on consecutive cycles.
